bcd_conv: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm.
- Sits directly downstream of the cubic/sqrt function unit and consumes its 25-bit result y_bo.
- Produces 8 packed BCD digits for the board's 7-segment display driver.
- Uses the same start/busy handshake as the function unit, so the two chain without glue logic.

---
 rtl/bcd_conv_if.sv | 37 +++
 rtl/bcd_conv.sv | 153 +++++++++++++++
 tb/tb_bcd_conv.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_if.sv
// Start/busy handshake and result bus between a binary producer and bcd_conv.
// The leading-zero blank mask exists only when FUNC_BCD_LZB_EN is defined.
interface bcd_conv_if #(
  parameter int IN_W   = 25,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [IN_W-1:0]       bin;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;
`ifdef FUNC_BCD_LZB_EN
  logic [DIGITS-1:0]     blank;
`endif

  modport master (
    output start,
    output bin,
    input  busy,
    input  valid,
`ifdef FUNC_BCD_LZB_EN
    input  blank,
`endif
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output valid,
`ifdef FUNC_BCD_LZB_EN
    output blank,
`endif
    output bcd
  );
endinterface

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional registered leading-zero blank mask under FUNC_BCD_LZB_EN.
module bcd_conv #(
  parameter int IN_W   = 25,
  parameter int DIGITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  bcd_conv_if.slave  bus
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int CAT_W = 4 * DIGITS + IN_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IN_W-1:0]       shift_r;
  logic [IN_W-1:0]       shift_nxt_s;
  logic [4*DIGITS-1:0]   work_r;
  logic [4*DIGITS-1:0]   work_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [4*DIGITS-1:0]   corrected_s;
  logic [CAT_W-1:0]      cat_s;
  logic                  done_s;
  logic [4*DIGITS-1:0]   bcd_r;
  logic                  valid_r;

  // Per-digit correction: each nibble >= 5 gets +3, no carry between digits.
  function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] w);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          d;
    r = w;
    for (int k = 0; k < DIGITS; k++) begin
      d = w[4*k +: 4];
      if (d >= 4'd5) begin
        r[4*k +: 4] = d + 4'd3;
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  assign corrected_s = add3_digits(work_r);
  assign cat_s       = {corrected_s, shift_r} << 1'b1;

  // Next-state and working-register update logic.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    work_nxt_s  = work_r;
    cnt_nxt_s   = cnt_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_CONV;
          shift_nxt_s = bus.bin;
          work_nxt_s  = {(4*DIGITS){1'b0}};
          cnt_nxt_s   = CNT_W'(IN_W - 1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        work_nxt_s  = cat_s[CAT_W-1:IN_W];
        shift_nxt_s = cat_s[IN_W-1:0];
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          done_s      = 1'b1;
        end else begin
          state_nxt_s = ST_CONV;
          cnt_nxt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, shift, working and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      shift_r <= {IN_W{1'b0}};
      work_r  <= {(4*DIGITS){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      work_r  <= work_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Result register: holds the previous result until the completing edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_r   <= {(4*DIGITS){1'b0}};
      valid_r <= 1'b0;
    end else begin
      valid_r <= done_s;
      if (done_s) begin
        bcd_r <= cat_s[CAT_W-1:IN_W];
      end else begin
        bcd_r <= bcd_r;
      end
    end
  end

  assign bus.busy  = (state_r == ST_CONV);
  assign bus.valid = valid_r;
  assign bus.bcd   = bcd_r;

`ifdef FUNC_BCD_LZB_EN
  logic [DIGITS-1:0] blank_r;

  // Bit k set when digit k and all above are zero; bit 0 never set.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] m;
    logic              z;
    m = {DIGITS{1'b0}};
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z    = z & (b[4*k +: 4] == 4'd0);
      m[k] = z;
    end
    return m;
  endfunction

  // Blank mask register, updated together with the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blank_r <= {DIGITS{1'b0}};
    end else if (done_s) begin
      blank_r <= lzb_mask(cat_s[CAT_W-1:IN_W]);
    end else begin
      blank_r <= blank_r;
    end
  end

  assign bus.blank = blank_r;
`endif

endmodule

// File: tb/tb_bcd_conv.sv
// Self-checking bench for bcd_conv: arithmetic reference model plus directed vectors.
module tb_bcd_conv;
  localparam int IN_W   = 25;
  localparam int DIGITS = 8;
  localparam int LAT    = 25;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b1;
  bit   clk_run = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bcd_conv_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  bcd_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = clk_run ? ~clk_i : 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, blank by magnitude comparison.
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = 32'h0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_blank(input int v);
    logic [7:0] m;
    int p;
    m = 8'h0;
    p = 1;
    for (int k = 1; k < DIGITS; k++) begin
      p = p * 10;
      m[k] = (v < p);
    end
    return m;
  endfunction

  int          m_cnt;
  int          m_val;
  logic [31:0] m_bcd;
  logic [7:0]  m_blank;
  logic        m_valid;

  // Cycle-level reference model of the handshake.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt   <= 0;
      m_val   <= 0;
      m_bcd   <= 32'h0;
      m_blank <= 8'h0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          m_cnt <= LAT;
          m_val <= int'(bus.bin);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_bcd   <= to_bcd(m_val);
          m_blank <= to_blank(m_val);
          m_valid <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk(bus.busy === (m_cnt != 0), "cyc_busy", {31'h0, bus.busy}, {31'h0, m_cnt != 0});
      chk(bus.valid === m_valid, "cyc_valid", {31'h0, bus.valid}, {31'h0, m_valid});
      chk(bus.bcd === m_bcd, "cyc_bcd", bus.bcd, m_bcd);
`ifdef FUNC_BCD_LZB_EN
      chk(bus.blank === m_blank, "cyc_blank", {24'h0, bus.blank}, {24'h0, m_blank});
`endif
    end
  end

  task automatic kick(input int v);
    @(negedge clk_i);
    bus.start = 1'b1;
    bus.bin   = IN_W'(v);
    @(negedge clk_i);
    bus.start = 1'b0;
    bus.bin   = IN_W'($urandom);
  endtask

  task automatic wait_done(input logic [31:0] exp, input logic [7:0] exp_blank, input string name,
                           input int inject_at, input logic [31:0] hold);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.bin   = {IN_W{1'b0}};
        chk(bus.bcd === hold, {name, "_hold"}, bus.bcd, hold);
      end else begin
        bus.start = 1'b0;
      end
      n++;
      @(negedge clk_i);
    end
    bus.start = 1'b0;
    chk(n == LAT, {name, "_latency"}, 32'(n), 32'(LAT));
    chk(bus.valid === 1'b1, {name, "_valid"}, {31'h0, bus.valid}, 32'h1);
    chk(bus.bcd === exp, {name, "_bcd"}, bus.bcd, exp);
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.bcd[4*k +: 4] > 4'd9) begin
        chk(1'b0, {name, "_digit_range"}, bus.bcd, exp);
      end
    end
`ifdef FUNC_BCD_LZB_EN
    chk(bus.blank === exp_blank, {name, "_blank"}, {24'h0, bus.blank}, {24'h0, exp_blank});
`else
    if (exp_blank == 8'hFF) begin
      chk(1'b0, {name, "_blank_arg"}, 32'h0, 32'h0);
    end
`endif
  endtask

  task automatic pulse_end(input string name);
    @(negedge clk_i);
    chk(bus.valid === 1'b0, {name, "_pulse_end"}, {31'h0, bus.valid}, 32'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = {IN_W{1'b0}};
    // Reset with the clock stopped: outputs must clear without an edge.
    #2 rst_ni = 1'b0;
    #1;
    chk(bus.busy === 1'b0, "rst_busy", {31'h0, bus.busy}, 32'h0);
    chk(bus.valid === 1'b0, "rst_valid", {31'h0, bus.valid}, 32'h0);
    chk(bus.bcd === 32'h0, "rst_bcd", bus.bcd, 32'h0);
`ifdef FUNC_BCD_LZB_EN
    chk(bus.blank === 8'h0, "rst_blank", {24'h0, bus.blank}, 32'h0);
`endif
    // Pin the reference model itself.
    chk(to_bcd(4107) === 32'h00004107, "model_bcd", to_bcd(4107), 32'h00004107);
    chk(to_blank(11) === 8'hFC, "model_blank", {24'h0, to_blank(11)}, 32'hFC);

    clk_run = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    kick(11);
    wait_done(32'h00000011, 8'hFC, "bin11", -1, 32'h0);
    pulse_end("bin11");

    kick(16581390);
    wait_done(32'h16581390, 8'h00, "bin16581390", -1, 32'h0);
    pulse_end("bin16581390");

    kick(33554431);
    wait_done(32'h33554431, 8'h00, "binmax", -1, 32'h0);
    pulse_end("binmax");

    kick(4107);
    wait_done(32'h00004107, 8'hF0, "busy_ignore", 5, 32'h33554431);
    pulse_end("busy_ignore");

    kick(0);
    wait_done(32'h00000000, 8'hFE, "bin0", -1, 32'h0);
    pulse_end("bin0");

    // Reset in the middle of a conversion.
    kick(79510);
    repeat (10) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk(bus.busy === 1'b0, "midrst_busy", {31'h0, bus.busy}, 32'h0);
    chk(bus.valid === 1'b0, "midrst_valid", {31'h0, bus.valid}, 32'h0);
    chk(bus.bcd === 32'h0, "midrst_bcd", bus.bcd, 32'h0);
`ifdef FUNC_BCD_LZB_EN
    chk(bus.blank === 8'h0, "midrst_blank", {24'h0, bus.blank}, 32'h0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    kick(157467);
    wait_done(32'h00157467, 8'hC0, "bin157467", -1, 32'h0);
    // Start on the valid cycle is accepted immediately.
    bus.start = 1'b1;
    bus.bin   = IN_W'(11);
    @(negedge clk_i);
    bus.start = 1'b0;
    bus.bin   = IN_W'($urandom);
    chk(bus.busy === 1'b1, "chain_busy", {31'h0, bus.busy}, 32'h1);
    chk(bus.valid === 1'b0, "chain_valid", {31'h0, bus.valid}, 32'h0);
    wait_done(32'h00000011, 8'hFC, "chain11", -1, 32'h0);
    pulse_end("chain11");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
